// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator for the GPU pixel pipeline.
//   Two free-running counters (SCREEN_X / SCREEN_Y) walk the full raster,
//   and every decoded output is registered from the current counter value.
//   Decoded outputs therefore lag the counters by exactly one clock.
//
// Ports
//   PIXEL_CLOCK  in   pixel clock, all logic on its rising edge
//   RESET_N      in   asynchronous active-low reset
//   ENABLE       in   1 = run, 0 = hold counters at origin with outputs inactive
//   IRQ_LINE     in   raster line that raises IRQ (COORD_W bits)
//   IRQ_ACK      in   clears IRQ (a simultaneous set wins)
//   SCREEN_X     out  horizontal counter
//   SCREEN_Y     out  vertical counter
//   Hs, Vs       out  sync outputs, active level set by HS_POL / VS_POL
//   ON_SCREEN    out  pixel inside the visible area
//   H_BLANK      out  horizontal blanking
//   V_BLANK      out  vertical blanking
//   LINE_START   out  one-clock strobe at X == 0
//   FRAME_START  out  one-clock strobe at X == 0, Y == 0
//   IRQ          out  raster interrupt, sticky until acknowledged
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COORD_W  = 10
) (
  input  logic               PIXEL_CLOCK,
  input  logic               RESET_N,
  input  logic               ENABLE,
  input  logic [COORD_W-1:0] IRQ_LINE,
  input  logic               IRQ_ACK,
  output logic [COORD_W-1:0] SCREEN_X,
  output logic [COORD_W-1:0] SCREEN_Y,
  output logic               Hs,
  output logic               Vs,
  output logic               ON_SCREEN,
  output logic               H_BLANK,
  output logic               V_BLANK,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic               IRQ
);

  // Timing landmarks, held at 32 bits so H_TOTAL may equal 2^COORD_W.
  localparam logic [31:0] H_TOTAL = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [31:0] V_TOTAL = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [31:0] H_VIS   = 32'(H_ACTIVE);
  localparam logic [31:0] V_VIS   = 32'(V_ACTIVE);
  localparam logic [31:0] HS_STA  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_STA  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END  = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] x_p0, y_p0;
  logic [31:0]        xw, yw;
  logic               x_last, y_last;
  logic               hs_act, vs_act, x_vis, y_vis, x_zero, y_zero;
  logic               hs_p1, vs_p1, on_p1, hb_p1, vb_p1, ls_p1, fs_p1, irq_p1;

  assign xw     = 32'(x_p0);
  assign yw     = 32'(y_p0);
  assign x_last = (xw == H_TOTAL - 32'd1);
  assign y_last = (yw == V_TOTAL - 32'd1);
  assign hs_act = (xw >= HS_STA) && (xw < HS_END);
  assign vs_act = (yw >= VS_STA) && (yw < VS_END);
  assign x_vis  = (xw < H_VIS);
  assign y_vis  = (yw < V_VIS);
  assign x_zero = (x_p0 == '0);
  assign y_zero = (y_p0 == '0);

  // ---- stage p0: raster counters ----
  // Disabling parks the counters at the origin, so a re-enable always
  // restarts at the top of the frame.
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (!ENABLE) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (x_last) begin
      x_p0 <= '0;
      y_p0 <= y_last ? '0 : y_p0 + ONE;
    end else begin
      x_p0 <= x_p0 + ONE;
    end
  end

  // ---- stage p1: registered decode of the p0 counters ----
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_p1 <= ~HS_POL;
      vs_p1 <= ~VS_POL;
      on_p1 <= 1'b0;
      hb_p1 <= 1'b0;
      vb_p1 <= 1'b0;
      ls_p1 <= 1'b0;
      fs_p1 <= 1'b0;
    end else if (!ENABLE) begin
      hs_p1 <= ~HS_POL;
      vs_p1 <= ~VS_POL;
      on_p1 <= 1'b0;
      hb_p1 <= 1'b0;
      vb_p1 <= 1'b0;
      ls_p1 <= 1'b0;
      fs_p1 <= 1'b0;
    end else begin
      hs_p1 <= hs_act ? HS_POL : ~HS_POL;
      vs_p1 <= vs_act ? VS_POL : ~VS_POL;
      on_p1 <= x_vis && y_vis;
      hb_p1 <= !x_vis;
      vb_p1 <= !y_vis;
      ls_p1 <= x_zero;
      fs_p1 <= x_zero && y_zero;
    end
  end

  // Raster IRQ fires together with the matching line's LINE_START; a line
  // number beyond the raster simply never matches. Set beats acknowledge.
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_p1 <= 1'b0;
    end else if (ENABLE && x_zero && (y_p0 == IRQ_LINE)) begin
      irq_p1 <= 1'b1;
    end else if (IRQ_ACK) begin
      irq_p1 <= 1'b0;
    end
  end

  assign SCREEN_X    = x_p0;
  assign SCREEN_Y    = y_p0;
  assign Hs          = hs_p1;
  assign Vs          = vs_p1;
  assign ON_SCREEN   = on_p1;
  assign H_BLANK     = hb_p1;
  assign V_BLANK     = vb_p1;
  assign LINE_START  = ls_p1;
  assign FRAME_START = fs_p1;
  assign IRQ         = irq_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Instance d uses the default 640x480
//   mode; instance s uses the small 16x8 mode with positive sync polarity.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-mode instance
  logic       d_rst_n, d_en, d_ack;
  logic [9:0] d_irq_line, d_x, d_y;
  logic       d_hs, d_vs, d_on, d_hb, d_vb, d_ls, d_fs, d_irq;

  // small-mode instance
  logic       s_rst_n, s_en, s_ack;
  logic [4:0] s_irq_line, s_x, s_y;
  logic       s_hs, s_vs, s_on, s_hb, s_vb, s_ls, s_fs, s_irq;

  int n_cmp = 0;
  int n_err = 0;

  vga_timing_gen dut_d (
    .PIXEL_CLOCK(clk), .RESET_N(d_rst_n), .ENABLE(d_en),
    .IRQ_LINE(d_irq_line), .IRQ_ACK(d_ack),
    .SCREEN_X(d_x), .SCREEN_Y(d_y), .Hs(d_hs), .Vs(d_vs),
    .ON_SCREEN(d_on), .H_BLANK(d_hb), .V_BLANK(d_vb),
    .LINE_START(d_ls), .FRAME_START(d_fs), .IRQ(d_irq)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(5)
  ) dut_s (
    .PIXEL_CLOCK(clk), .RESET_N(s_rst_n), .ENABLE(s_en),
    .IRQ_LINE(s_irq_line), .IRQ_ACK(s_ack),
    .SCREEN_X(s_x), .SCREEN_Y(s_y), .Hs(s_hs), .Vs(s_vs),
    .ON_SCREEN(s_on), .H_BLANK(s_hb), .V_BLANK(s_vb),
    .LINE_START(s_ls), .FRAME_START(s_fs), .IRQ(s_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_low, hs_first, on_cnt, last_ls, irq_rise, guard, irq_hits;
    int xd, yd;

    d_rst_n = 1'b0; d_en = 1'b1; d_ack = 1'b0; d_irq_line = 10'd1;
    s_rst_n = 1'b0; s_en = 1'b1; s_ack = 1'b0; s_irq_line = 5'd3;

    // ---------------- reset state ----------------
    #23;
    chk("rst_d_x", d_x, 0);
    chk("rst_d_y", d_y, 0);
    chk("rst_d_hs", d_hs, 1);
    chk("rst_d_vs", d_vs, 1);
    chk("rst_d_on", d_on, 0);
    chk("rst_d_hb", d_hb, 0);
    chk("rst_d_vb", d_vb, 0);
    chk("rst_d_ls", d_ls, 0);
    chk("rst_d_fs", d_fs, 0);
    chk("rst_d_irq", d_irq, 0);
    chk("rst_s_hs", s_hs, 0);
    chk("rst_s_vs", s_vs, 0);
    chk("rst_s_x", s_x, 0);

    // release off the clock edge; first edge decodes (0,0)
    d_rst_n = 1'b1;
    tick();
    chk("first_x", d_x, 1);
    chk("first_y", d_y, 0);
    chk("first_fs", d_fs, 1);
    chk("first_ls", d_ls, 1);
    chk("first_on", d_on, 1);
    chk("first_hb", d_hb, 0);
    chk("first_hs", d_hs, 1);

    // ---------------- default mode, three lines ----------------
    hs_low = 0; hs_first = -1; on_cnt = 0; last_ls = 1; irq_rise = -1;
    for (int k = 2; k <= 2400; k++) begin
      tick();
      chk("d_x", d_x, k % 800);
      chk("d_y", d_y, k / 800);
      if (k == 2) chk("fs_one_clock", d_fs, 0);
      if (k >= 801 && k <= 1600) begin
        if (!d_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(d_x);
        end
        if (d_on) on_cnt++;
      end
      if (d_ls) begin
        chk("ls_period", k - last_ls, 800);
        last_ls = k;
      end
      if (d_irq && irq_rise < 0) begin
        irq_rise = k;
        chk("irq_with_ls", d_ls, 1);
      end
    end
    chk("hs_low_clocks", hs_low, 96);
    chk("hs_first_x", hs_first, 657);
    chk("on_clocks", on_cnt, 640);
    chk("irq_rise_edge", irq_rise, 801);
    chk("ls_count_end", last_ls, 1601);
    chk("vb_visible", d_vb, 0);
    chk("vs_visible", d_vs, 1);

    // ---------------- ENABLE dropped mid-line ----------------
    guard = 0;
    while (d_x != 10'd300 && guard < 1000) begin
      tick();
      guard++;
    end
    chk("wait_x300", d_x, 300);
    chk("pre_drop_y", d_y, 3);
    chk("pre_drop_on", d_on, 1);
    d_en = 1'b0;
    tick();
    chk("dis_x", d_x, 0);
    chk("dis_y", d_y, 0);
    chk("dis_hs", d_hs, 1);
    chk("dis_vs", d_vs, 1);
    chk("dis_on", d_on, 0);
    chk("dis_hb", d_hb, 0);
    chk("dis_ls", d_ls, 0);
    chk("dis_irq_hold", d_irq, 1);
    tick();
    d_ack = 1'b1;
    tick();
    chk("dis_ack_clears", d_irq, 0);
    d_ack = 1'b0;
    tick();
    tick();
    chk("dis_x_held", d_x, 0);
    d_en = 1'b1;
    tick();
    chk("reen_fs", d_fs, 1);
    chk("reen_ls", d_ls, 1);
    chk("reen_on", d_on, 1);
    chk("reen_x", d_x, 1);
    chk("reen_y", d_y, 0);
    tick();
    chk("reen_fs_drop", d_fs, 0);
    chk("reen_x2", d_x, 2);

    // ---------------- async reset mid-line ----------------
    guard = 0;
    while (!d_irq && guard < 2000) begin
      tick();
      guard++;
    end
    chk("irq_again", d_irq, 1);
    chk("irq_again_x", d_x, 1);
    chk("irq_again_y", d_y, 1);
    #3;
    d_rst_n = 1'b0;
    #1;
    chk("arst_x", d_x, 0);
    chk("arst_y", d_y, 0);
    chk("arst_on", d_on, 0);
    chk("arst_ls", d_ls, 0);
    chk("arst_irq", d_irq, 0);
    chk("arst_hs", d_hs, 1);
    #2;
    d_rst_n = 1'b1;
    tick();
    chk("arst_resume_x", d_x, 1);
    chk("arst_resume_y", d_y, 0);
    chk("arst_resume_fs", d_fs, 1);

    // ---------------- small mode, two frames ----------------
    @(negedge clk);
    s_rst_n = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      xd = (k - 1) % 16;
      yd = ((k - 1) / 16) % 8;
      chk("s_x", s_x, k % 16);
      chk("s_y", s_y, (k / 16) % 8);
      chk("s_hs", s_hs, (xd == 10 || xd == 11) ? 1 : 0);
      chk("s_vs", s_vs, (yd == 5) ? 1 : 0);
      chk("s_fs", s_fs, (xd == 0 && yd == 0) ? 1 : 0);
      chk("s_ls", s_ls, (xd == 0) ? 1 : 0);
      chk("s_on", s_on, (xd < 8 && yd < 4) ? 1 : 0);
      chk("s_hb", s_hb, (xd >= 8) ? 1 : 0);
      chk("s_vb", s_vb, (yd >= 4) ? 1 : 0);
      chk("s_irq", s_irq, (k >= 49) ? 1 : 0);
    end

    // ---------------- IRQ acknowledge ----------------
    s_ack = 1'b1;
    tick();
    chk("s_ack_clear", s_irq, 0);
    s_ack = 1'b0;
    for (int k = 258; k <= 304; k++) begin
      tick();
      chk("s_irq_quiet", s_irq, 0);
    end
    s_ack = 1'b1;
    tick();
    chk("s_set_beats_ack", s_irq, 1);
    chk("s_set_ls", s_ls, 1);
    chk("s_set_y", s_y, 3);
    tick();
    chk("s_ack_after_set", s_irq, 0);
    s_ack = 1'b0;

    // ---------------- IRQ line beyond raster ----------------
    s_irq_line = 5'd10;
    irq_hits = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (s_irq) irq_hits++;
    end
    chk("s_irq_out_of_range", irq_hits, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
